// File: rtl/coreuart_pkg.sv
// Shared constants and elaboration helpers for the CoreUART FIFO slice.
package coreuart_pkg;

  localparam int FIFO_DEPTH_DEF     = 256;
  localparam int FIFO_WIDTH_DEF     = 8;
  localparam int FIFO_AFULL_TH_DEF  = 255;
  localparam int FIFO_AEMPTY_TH_DEF = 8;

  // Ceiling log2, evaluated at elaboration to size pointers and the level port.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/coreuart_fifo_ram.sv
// Simple dual-port register array: synchronous write, asynchronous read.
module coreuart_fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/coreuart_fifo_param.sv
// Parametrised single-clock FIFO for the CoreUART TX/RX paths; all status
// flags are registered from the next-state occupancy count.
module coreuart_fifo_param
  import coreuart_pkg::*;
#(
  parameter int WIDTH     = FIFO_WIDTH_DEF,
  parameter int DEPTH     = FIFO_DEPTH_DEF,
  parameter int AFULL_TH  = FIFO_AFULL_TH_DEF,
  parameter int AEMPTY_TH = FIFO_AEMPTY_TH_DEF,
  parameter int FWFT      = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      data_in,
  input  logic                  wrb,
  input  logic                  rdb,
  input  logic                  flush,
  output logic [WIDTH-1:0]      data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  afull,
  output logic                  aempty,
  output logic [clog2(DEPTH):0] level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
  localparam logic [AW:0] AFULL_C  = (AW+1)'(AFULL_TH);
  localparam logic [AW:0] AEMPTY_C = (AW+1)'(AEMPTY_TH);

  generate
    if (!is_pow2(DEPTH) || DEPTH < 4 || DEPTH > 1024 || WIDTH < 1 || WIDTH > 32 ||
        AFULL_TH < 1 || AFULL_TH > DEPTH || AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1 ||
        (FWFT != 0 && FWFT != 1)) begin : g_bad_params
      $error("coreuart_fifo_param: illegal parameter combination");
    end
  endgenerate

  logic [1:0]       rst_sync;
  logic             srst_n;
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [AW:0]      cnt;
  logic [AW:0]      cnt_next;
  logic             wr_acc;
  logic             rd_acc;
  logic [WIDTH-1:0] ram_rd;
  logic [WIDTH-1:0] dout_q;

  // Reset asserts immediately but is released only after two clock edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign srst_n = rst_sync[1];

  always_comb begin
    wr_acc   = !wrb && !full && !flush;
    rd_acc   = !rdb && !empty && !flush;
    cnt_next = cnt;
    if (flush) cnt_next = '0;
    else       cnt_next = cnt + {{AW{1'b0}}, wr_acc} - {{AW{1'b0}}, rd_acc};
  end

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      wp        <= '0;
      rp        <= '0;
      cnt       <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      afull     <= 1'b0;
      aempty    <= 1'b1;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      dout_q    <= '0;
    end else begin
      cnt    <= cnt_next;
      full   <= (cnt_next == DEPTH_C);
      empty  <= (cnt_next == '0);
      afull  <= (cnt_next >= AFULL_C);
      aempty <= (cnt_next <= AEMPTY_C);
      if (flush) begin
        wp        <= '0;
        rp        <= '0;
        overflow  <= 1'b0;
        underflow <= 1'b0;
        dout_q    <= '0;
      end else begin
        if (wr_acc) wp <= wp + AW'(1);
        if (rd_acc) begin
          rp     <= rp + AW'(1);
          dout_q <= ram_rd;
        end
        if (!wrb && full)  overflow  <= 1'b1;
        if (!rdb && empty) underflow <= 1'b1;
      end
    end
  end

  assign level = cnt;

  coreuart_fifo_ram #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_ram (
    .clk  (clk),
    .we   (wr_acc),
    .waddr(wp),
    .wdata(data_in),
    .raddr(rp),
    .rdata(ram_rd)
  );

  // In fall-through mode the head entry is shown directly; zero while empty.
  generate
    if (FWFT != 0) begin : g_fwft
      assign data_out = empty ? '0 : ram_rd;
    end else begin : g_std
      assign data_out = dout_q;
    end
  endgenerate

endmodule

// File: tb/tb_coreuart_fifo_param.sv
// Scoreboard bench: a standard-mode and a fall-through FIFO share one stimulus
// stream and are compared against a queue model after every clock.
module tb_coreuart_fifo_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       wrb = 1'b1;
  logic       rdb = 1'b1;
  logic       flush = 1'b0;

  logic [7:0] s_data_out, f_data_out;
  logic       s_full, s_empty, s_afull, s_aempty, s_overflow, s_underflow;
  logic       f_full, f_empty, f_afull, f_aempty, f_overflow, f_underflow;
  logic [8:0] s_level, f_level;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb[$];
  bit         modelOvf = 1'b0;
  bit         modelUnf = 1'b0;
  logic [7:0] expDout = 8'h00;

  always #5 clk = ~clk;

  coreuart_fifo_param #(.FWFT(0)) u_std (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .wrb(wrb), .rdb(rdb), .flush(flush),
    .data_out(s_data_out), .full(s_full), .empty(s_empty), .afull(s_afull),
    .aempty(s_aempty), .level(s_level), .overflow(s_overflow), .underflow(s_underflow)
  );

  coreuart_fifo_param #(.FWFT(1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .wrb(wrb), .rdb(rdb), .flush(flush),
    .data_out(f_data_out), .full(f_full), .empty(f_empty), .afull(f_afull),
    .aempty(f_aempty), .level(f_level), .overflow(f_overflow), .underflow(f_underflow)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Everything the model can predict from the current queue contents.
  task automatic checkAll(input string tag);
    int n;
    n = sb.size();
    checkOutput({tag, " level"},     32'(s_level),  32'(n));
    checkOutput({tag, " full"},      32'(s_full),   32'(n == 256));
    checkOutput({tag, " empty"},     32'(s_empty),  32'(n == 0));
    checkOutput({tag, " afull"},     32'(s_afull),  32'(n >= 255));
    checkOutput({tag, " aempty"},    32'(s_aempty), 32'(n <= 8));
    checkOutput({tag, " overflow"},  32'(s_overflow),  32'(modelOvf));
    checkOutput({tag, " underflow"}, 32'(s_underflow), 32'(modelUnf));
    checkOutput({tag, " dout"},      32'(s_data_out),  32'(expDout));
    checkOutput({tag, " f_level"},   32'(f_level),  32'(n));
    checkOutput({tag, " f_empty"},   32'(f_empty),  32'(n == 0));
    if (n > 0) checkOutput({tag, " f_dout"}, 32'(f_data_out), 32'(sb[0]));
  endtask

  // One clock of stimulus, then the model absorbs what the FIFO should have done.
  task automatic applyStimulus(input bit w, input bit r, input bit fl, input logic [7:0] d);
    int n;
    n = sb.size();
    wrb = !w;
    rdb = !r;
    flush = fl;
    data_in = d;
    @(posedge clk);
    #1;
    wrb = 1'b1;
    rdb = 1'b1;
    flush = 1'b0;
    if (fl) begin
      sb.delete();
      modelOvf = 1'b0;
      modelUnf = 1'b0;
      expDout = 8'h00;
    end else begin
      if (w && n == 256) modelOvf = 1'b1;
      if (r && n == 0)   modelUnf = 1'b1;
      if (r && n > 0)    expDout = sb.pop_front();
      if (w && n < 256)  sb.push_back(d);
    end
  endtask

  task automatic releaseReset();
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #11;
    checkAll("reset");
    releaseReset();
    checkAll("post_reset");

    for (int i = 0; i < 256; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 8'(i));
      checkAll($sformatf("fill%0d", i));
    end
    checkOutput("full_after_256", 32'(s_full), 32'd1);

    applyStimulus(1'b1, 1'b0, 1'b0, 8'hEE);
    checkAll("write257");
    checkOutput("overflow_set", 32'(s_overflow), 32'd1);

    applyStimulus(1'b1, 1'b1, 1'b0, 8'h77);
    checkAll("full_wr_rd");
    checkOutput("full_wr_rd_level", 32'(s_level), 32'd255);

    for (int i = 0; i < 255; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
      checkAll($sformatf("drain%0d", i));
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    checkAll("extra_read");
    checkOutput("underflow_set", 32'(s_underflow), 32'd1);
    checkOutput("dout_holds_ff", 32'(s_data_out), 32'hFF);

    applyStimulus(1'b1, 1'b0, 1'b0, 8'hA5);
    checkAll("fwft_write");
    checkOutput("fwft_head_a5", 32'(f_data_out), 32'hA5);
    checkOutput("fwft_not_empty", 32'(f_empty), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    checkAll("fwft_pop");

    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 8'($urandom_range(0, 255)));
      checkAll($sformatf("fill100_%0d", i));
    end
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h11);
    checkAll("flush");
    checkOutput("flush_level", 32'(s_level), 32'd0);
    checkOutput("flush_dout", 32'(s_data_out), 32'd0);
    checkOutput("flush_underflow", 32'(s_underflow), 32'd0);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
      checkAll($sformatf("fill10_%0d", i));
    end
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 8'($urandom_range(0, 255)));
      checkAll($sformatf("pair%0d", i));
    end
    checkOutput("pairs_level10", 32'(s_level), 32'd10);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
      checkAll($sformatf("drain10_%0d", i));
    end

    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 8'(8'hC0 + i));
    end
    wrb = 1'b0;
    data_in = 8'h99;
    #2 rst_n = 1'b0;
    #1;
    sb.delete();
    modelOvf = 1'b0;
    modelUnf = 1'b0;
    expDout = 8'h00;
    checkAll("async_reset");
    wrb = 1'b1;
    #3;
    releaseReset();
    checkAll("after_reset");
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h3C);
    checkAll("new_write");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    checkAll("new_read");
    checkOutput("new_data_3c", 32'(s_data_out), 32'h3C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/coreuart_fifo_param.md
# coreuart_fifo_param

Parametrised single-clock FIFO for the CoreUARTapb datapath, replacing the fixed 256x8 hard-macro FIFO in both the TX and RX paths. It has generic width and depth, and all status flags are computed from an occupancy counter. It adds features the fixed FIFO lacks: programmable almost-full/almost-empty thresholds, a level output, sticky overflow/underflow flags, synchronous flush, and an optional first-word-fall-through (FWFT) read mode. It sits between the APB register interface and the UART TX/RX shift engines.

## Interface
- WIDTH, default 8: data width in bits, 1..32.
- DEPTH, default 256: number of entries; must be a power of 2, 4..1024.
- AFULL_TH, default 255: AFULL asserts when LEVEL >= AFULL_TH; valid range 1..DEPTH.
- AEMPTY_TH, default 8: AEMPTY asserts when LEVEL <= AEMPTY_TH; valid range 0..DEPTH-1.
- FWFT, default 0: 0 = standard read (registered, 1-cycle latency); 1 = first-word fall-through.
- CLK  in  1  sole clock; all logic is rising-edge.
- RESET  in  1  asynchronous, active-low reset.
- DATA_IN  in  WIDTH  write data.
- WRB  in  1  active-low write enable.
- RDB  in  1  active-low read enable / pop.
- FLUSH  in  1  active-high synchronous clear.
- DATA_OUT  out  WIDTH  read data.
- FULL, EMPTY, AFULL, AEMPTY  out  1  status flags.
- LEVEL  out  AW+1  occupancy, where AW = log2(DEPTH).
- OVERFLOW, UNDERFLOW  out  1  sticky error flags.

## Operation
- Storage is DEPTH x WIDTH. Write pointer wp and read pointer rp are each AW bits and wrap naturally from DEPTH-1 to 0. A counter cnt of AW+1 bits drives LEVEL.
- Write is accepted when WRB=0 and FULL=0: mem[wp]<=DATA_IN, wp++.
- Write with WRB=0 and FULL=1 is dropped; it sets OVERFLOW and leaves memory and pointers unchanged.
- Read is accepted when RDB=0 and EMPTY=0: rp++.
- Read with RDB=0 and EMPTY=1 is ignored; it sets UNDERFLOW and leaves DATA_OUT unchanged.
- Simultaneous write and read:
  - Both accepted: cnt is unchanged, both pointers advance.
  - When FULL: only the read happens; the write is dropped and OVERFLOW is set.
  - When EMPTY: only the write happens and UNDERFLOW is set.
- Counter update: cnt_next = cnt + wr_acc - rd_acc. It never exceeds DEPTH and never goes below 0.
- Flags are registered, from cnt_next:
  - FULL = (cnt==DEPTH)
  - EMPTY = (cnt==0)
  - AFULL = (cnt>=AFULL_TH)
  - AEMPTY = (cnt<=AEMPTY_TH)
- FLUSH=1 has priority over read and write in the same cycle. It sets wp=rp=cnt=0, DATA_OUT=0 and clears OVERFLOW/UNDERFLOW. Memory contents are not cleared.
- Standard mode (FWFT=0): on an accepted read, DATA_OUT<=mem[rp] and holds until the next accepted read.
- FWFT mode (FWFT=1): DATA_OUT always presents mem[rp], the head entry, and is valid whenever EMPTY=0. An accepted read advances to the next entry.
- Reset values: DATA_OUT=0, LEVEL=0, EMPTY=1, AEMPTY=1, FULL=0, AFULL=0, OVERFLOW=0, UNDERFLOW=0. Pointers are 0.
- Reset asserted mid-operation discards all content immediately, asynchronously.

## Timing
- Write-to-flags latency: 1 cycle. A write at edge N is reflected in LEVEL and the flags after edge N.
- Standard read latency: DATA_OUT is valid after the edge that accepts the read.
- FWFT: after a write into an empty FIFO at edge N, EMPTY falls and DATA_OUT shows that word after edge N. Zero-latency pop: the next word is visible after the popping edge.
- Reading and writing the same address in one cycle cannot occur, because a read on an empty FIFO is not accepted.
- Reset release is synchronised internally: two flops, deassertion on CLK.
- There are no combinational paths from inputs to outputs, except DATA_OUT from the memory array in FWFT mode.

## Structure
- Shared package coreuart_pkg holds:
  - constants FIFO_DEPTH_DEF=256 and FIFO_WIDTH_DEF=8;
  - a constant log2 function used to derive AW;
  - threshold defaults.
- Sub-module coreuart_fifo_ram: simple dual-port register array with a synchronous write port and an asynchronous read port. The top level holds pointers, counter, flags and the output register.
- Parameter legality (DEPTH power of 2, threshold ranges) is checked at elaboration by a simulation-only assertion.

## Test plan
- Reset, then 256 writes of 0x00..0xFF: FULL=1 after the 256th write, and AFULL=1 from LEVEL=255. A 257th write leaves LEVEL=256 and sets OVERFLOW=1.
- Drain 256 reads in standard mode: DATA_OUT is 0x00..0xFF in order, each 1 cycle after its read. EMPTY=1 after the last read; an extra read sets UNDERFLOW and DATA_OUT holds 0xFF.
- With the FIFO full, simultaneous WRB=0/RDB=0: LEVEL goes 256 to 255 and the write is dropped. With LEVEL=10, simultaneous read and write: LEVEL stays 10 and order is preserved.
- FWFT=1: write 0xA5 into an empty FIFO; the next cycle gives EMPTY=0 and DATA_OUT=0xA5 with no read pulse.
- Fill 100 entries, then assert FLUSH together with WRB=0: the next cycle gives LEVEL=0, EMPTY=1, DATA_OUT=0 and error flags cleared. Wrap test: 300 write/read pairs show correct data across the pointer wrap.
- Assert RESET low asynchronously mid-burst: outputs go to their reset values immediately without a clock edge; after release, the first write and read returns the new data.
